// File: rtl/mult_signed_arbiter_pkg.sv
// Shared definitions for the round-robin signed multiplier scheduler:
// FSM state encoding and the clog2 helper used to size requester indices.
package mult_signed_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Ceiling log2, usable in constant expressions for index widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mult_signed_arbiter_if.sv
// Requester and result handshake bundle of the shared multiplier.
// master: requesters/consumer side; slave: the scheduler itself.
interface mult_signed_arbiter_if
    import mult_signed_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_REQ    = 4
);
    localparam int ID_WIDTH = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            REQ_VALID;
    logic [NUM_REQ-1:0]            REQ_READY;
    logic [NUM_REQ*DATA_WIDTH-1:0] REQ_A;
    logic [NUM_REQ*DATA_WIDTH-1:0] REQ_B;
    logic                          RES_VALID;
    logic                          RES_READY;
    logic [2*DATA_WIDTH-1:0]       RES_DATA;
    logic [ID_WIDTH-1:0]           RES_ID;
    logic                          BUSY;

    modport master (
        output REQ_VALID, REQ_A, REQ_B, RES_READY,
        input  REQ_READY, RES_VALID, RES_DATA, RES_ID, BUSY
    );

    modport slave (
        input  REQ_VALID, REQ_A, REQ_B, RES_READY,
        output REQ_READY, RES_VALID, RES_DATA, RES_ID, BUSY
    );

endinterface

// File: rtl/mult_signed_arbiter_mult.sv
// Shared full-precision signed multiplier. Both operands are sign-extended
// to the product width so the result never saturates or wraps.
module MULT_LUT_SIGNED #(
    parameter int DATA_WIDTH = 6
) (
    input  logic signed [DATA_WIDTH-1:0]   op_a,
    input  logic signed [DATA_WIDTH-1:0]   op_b,
    output logic signed [2*DATA_WIDTH-1:0] product
);
    localparam int PW = 2 * DATA_WIDTH;

    assign product = PW'(op_a) * PW'(op_b);

endmodule

// File: rtl/mult_signed_arbiter.sv
// Round-robin scheduler sharing one signed multiplier among NUM_REQ
// requesters. A granted operand pair is registered (IDLE), multiplied from
// the registers only (CALC), and the product is held until consumed (HOLD).
module mult_signed_arbiter
    import mult_signed_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_REQ    = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    mult_signed_arbiter_if.slave  bus
);
    localparam int ID_WIDTH = clog2(NUM_REQ);
    localparam int SW       = ID_WIDTH + 1;
    localparam int PW       = 2 * DATA_WIDTH;

    state_t                        state_r;
    state_t                        state_next_s;
    logic [ID_WIDTH-1:0]           ptr_r;
    logic signed [DATA_WIDTH-1:0]  op_a_r;
    logic signed [DATA_WIDTH-1:0]  op_b_r;
    logic [ID_WIDTH-1:0]           op_id_r;
    logic signed [PW-1:0]          product_s;
    logic [PW-1:0]                 res_data_r;
    logic [ID_WIDTH-1:0]           res_id_r;
    logic                          res_valid_r;
    logic                          busy_r;
    logic                          grant_found_s;
    logic [ID_WIDTH-1:0]           grant_idx_s;
    logic [SW-1:0]                 scan_idx_s;
    logic [NUM_REQ-1:0]            req_ready_s;
    logic                          handshake_s;

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        scan_idx_s    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            scan_idx_s = {1'b0, ptr_r} + SW'(off);
            if (scan_idx_s >= SW'(NUM_REQ)) begin
                scan_idx_s = scan_idx_s - SW'(NUM_REQ);
            end else begin
                scan_idx_s = scan_idx_s;
            end
            if (!grant_found_s && bus.REQ_VALID[scan_idx_s[ID_WIDTH-1:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = scan_idx_s[ID_WIDTH-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot grant, only offered while idle and out of reset.
    always_comb begin
        req_ready_s = '0;
        if (nRST && (state_r == ST_IDLE) && grant_found_s) begin
            req_ready_s = NUM_REQ'(1) << grant_idx_s;
        end else begin
            req_ready_s = '0;
        end
    end

    assign handshake_s = |(bus.REQ_VALID & req_ready_s);

    // Next-state logic for the IDLE -> CALC -> HOLD cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (handshake_s) begin
                    state_next_s = ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: state_next_s = ST_HOLD;
            ST_HOLD: begin
                if (bus.RES_READY) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register; BUSY is registered alongside from the next state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    // Operand capture, pointer advance and result registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr_r       <= '0;
            op_a_r      <= '0;
            op_b_r      <= '0;
            op_id_r     <= '0;
            res_data_r  <= '0;
            res_id_r    <= '0;
            res_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (handshake_s) begin
                        op_a_r  <= bus.REQ_A[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
                        op_b_r  <= bus.REQ_B[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
                        op_id_r <= grant_idx_s;
                        if (grant_idx_s == ID_WIDTH'(NUM_REQ - 1)) begin
                            ptr_r <= '0;
                        end else begin
                            ptr_r <= grant_idx_s + ID_WIDTH'(1);
                        end
                    end
                end
                ST_CALC: begin
                    res_data_r  <= product_s;
                    res_id_r    <= op_id_r;
                    res_valid_r <= 1'b1;
                end
                ST_HOLD: begin
                    if (bus.RES_READY) begin
                        res_valid_r <= 1'b0;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    MULT_LUT_SIGNED #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mult (
        .op_a    (op_a_r),
        .op_b    (op_b_r),
        .product (product_s)
    );

    assign bus.REQ_READY = req_ready_s;
    assign bus.RES_VALID = res_valid_r;
    assign bus.RES_DATA  = res_data_r;
    assign bus.RES_ID    = res_id_r;
    assign bus.BUSY      = busy_r;

endmodule

// File: doc/mult_signed_arbiter.md
# mult_signed_arbiter

Round-robin scheduler that shares one signed array multiplier (`MULT_LUT_SIGNED`) between `NUM_REQ` requesters. Each requester issues an operand pair through a valid/ready handshake. The block registers the operands, holds them stable for one settle cycle, and registers the product. It returns the product with the winning requester's index over a valid/ready result port. It sits between the spike-processing front-ends and the shared arithmetic datapath on the FPGA, so one multiplier serves all channels.

## Interface
- `DATA_WIDTH`, 6: operand width in bits, two's complement; product is `2*DATA_WIDTH` bits.
- `NUM_REQ`, 4: number of requesters, at least 2.
- `ID_WIDTH`, `$clog2(NUM_REQ)`: derived, not overridden.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `REQ_VALID`  in  `NUM_REQ`  bit i: requester i presents operands.
- `REQ_READY`  out  `NUM_REQ`  one-hot grant; handshake completes for i when `REQ_VALID[i] & REQ_READY[i]`.
- `REQ_A`  in  `NUM_REQ*DATA_WIDTH`  packed signed operand A; slice i is `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `REQ_B`  in  `NUM_REQ*DATA_WIDTH`  packed signed operand B, same packing as `REQ_A`.
- `RES_VALID`  out  1  result available.
- `RES_READY`  in  1  consumer accepts the result.
- `RES_DATA`  out  `2*DATA_WIDTH`  signed product `A*B`.
- `RES_ID`  out  `ID_WIDTH`  index of the requester that owns `RES_DATA`.
- `BUSY`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, CALC, HOLD.
- **IDLE**
  - `REQ_READY` is combinational: one-hot on the first i with `REQ_VALID[i]`=1, searching from priority pointer `ptr` upward, modulo `NUM_REQ`.
  - All zero if no request is valid.
  - On handshake: latch `REQ_A` slice, `REQ_B` slice and index i into the operand registers; `ptr <= (i+1) mod NUM_REQ`; go to CALC.
- **CALC**
  - `REQ_READY` = 0.
  - Multiplier inputs come only from the operand registers.
  - At the cycle end: `RES_DATA <= product`, `RES_ID <= latched index`, `RES_VALID <= 1`; go to HOLD.
- **HOLD**
  - `REQ_READY` = 0.
  - `RES_DATA`, `RES_ID` and `RES_VALID` stay stable until `RES_READY`=1.
  - On `RES_READY`=1: `RES_VALID <= 0`; go to IDLE.
- Arithmetic: full-precision signed product with no saturation. The range `[-2^(DATA_WIDTH-1)]^2` fits, e.g. -32 × -32 = 1024 at width 6.
- Requesters are not obliged to hold `REQ_VALID` until granted. Dropping it before a handshake discards the request and leaves `ptr` unchanged.
- `REQ_READY` in IDLE depends combinationally on `REQ_VALID`. Requesters must not derive `REQ_VALID` from `REQ_READY`.
- `RES_READY` outside HOLD is ignored.

## Timing
- Reset values: state IDLE, `ptr`=0, `REQ_READY`=0 (no valid request), `RES_VALID`=0, `RES_DATA`=0, `RES_ID`=0, `BUSY`=0, operand registers 0.
- Latency: handshake in cycle n, then `RES_VALID` is high from cycle n+2.
- Throughput with `RES_READY` held high: one product every 3 cycles (IDLE, CALC, HOLD).
- Back-pressure: each cycle of `RES_READY`=0 in HOLD extends HOLD by one cycle. No new request is granted meanwhile.
- Simultaneous requests: exactly one grant per IDLE cycle. Every continuously-valid requester is served within `NUM_REQ` grants.
- Pointer wrap: a grant to `NUM_REQ-1` sets `ptr` to 0.
- `nRST` asserted mid-operation: immediate return to reset values. An in-flight or unconsumed result is dropped without a handshake.

## Structure
- Shared package holds:
  - State encoding constants (IDLE=2'd0, CALC=2'd1, HOLD=2'd2).
  - The `clog2` helper used for `ID_WIDTH`.
- One sub-module: a single instance of `MULT_LUT_SIGNED` with `DATA_WIDTH` passed through, fed only by the operand registers.
- Round-robin pick and FSM are inline. Target 150–250 lines.

## Test plan
- Reset: hold `nRST`=0 with random inputs → all outputs zero, `BUSY`=0. Release → IDLE, no grant without `REQ_VALID`.
- Single request, default widths: `REQ_VALID`=4'b0100, A2=-32, B2=-32, `RES_READY`=1 → `REQ_READY`=4'b0100 in the request cycle; 2 cycles later `RES_VALID`=1, `RES_DATA`=1024, `RES_ID`=2; next request can be granted in the cycle after the result handshake.
- Sign extremes: (31, -32) → -992; (-1, -1) → 1; (0, -17) → 0; (31, 31) → 961.
- Fairness: all four `REQ_VALID` held high, `RES_READY`=1 → grant order 0,1,2,3,0; each result at 3-cycle spacing with the matching `RES_ID`.
- Back-pressure: `RES_READY`=0 for 5 cycles in HOLD → `RES_DATA`/`RES_ID` constant, `REQ_READY`=0 throughout; release → exactly one result handshake.
- Reset mid-CALC: `nRST` pulsed low during CALC → `RES_VALID` never asserts for that request, `ptr` back to 0, next grant goes to lowest-index valid requester.
